multicycle_controller: RTL and testbench

Control unit for the multi-cycle RV32I core. It sequences the shared-memory datapath one instruction at a time through fetch, decode, execute, memory and writeback states. It drives every enable and mux select of the datapath, and decodes the ALU operation. It sits inside the core beside the datapath and owns the only path to the shared memory's write enable.

---
 rtl/multicycle_controller.sv | 170 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core: steps each instruction through its
// states and decodes every datapath enable, mux select and ALU operation.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       retire,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic       pc_update, branch;
  logic [1:0] alu_op;
  logic       funct_ok;

  // ALU-class instructions with an unimplemented funct3 are treated as illegal
  assign funct_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    alu_op    = 2'b00;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = funct_ok ? S_EXECUTER : S_TRAP;
          7'b0010011:             state_d = funct_ok ? S_EXECUTEI : S_TRAP;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = S_JAL;
          default:                state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        retire  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        halted  = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign PCWrite = pc_update | (branch & Zero);

  // subtract only for R-type with funct7b5; addi ignores bit 30
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by
// cycle and compares the packed output vector against hand-computed values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b010;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       RegWrite, retire, halted;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite),
    .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  // bit order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl RegWrite retire halted
  function automatic logic [17:0] obs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ImmSrc, ALUControl, RegWrite, retire, halted};
  endfunction

  function automatic logic [17:0] pk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [2:0] alu,
                                     input logic rw, input logic ret, input logic hlt);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ret, hlt};
  endfunction

  task automatic test_reset();
    logic [17:0] exp_v;
    exp_v = pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %b expected %b", i, obs(), exp_v);
      end
    end
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  task automatic test_lw();
    logic [17:0] exp_v[5];
    exp_v[0] = pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0);
    exp_v[1] = pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0, 0);
    exp_v[2] = pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0);
    exp_v[3] = pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0);
    exp_v[4] = pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0);
    @(negedge clk);
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("[TB] FAIL lw cycle %0d: got %b expected %b", i, obs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [17:0] exp_v[4];
    exp_v[0] = pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0, 0);
    exp_v[1] = pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0, 0, 0);
    exp_v[2] = pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0, 0);
    exp_v[3] = pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 1, 0);
    @(negedge clk);
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("[TB] FAIL sw cycle %0d: got %b expected %b", i, obs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_alu();
    logic [6:0]  t_op[6]  = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0110011};
    logic [2:0]  t_f3[6]  = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b110, 3'b010};
    logic        t_f7[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  t_alu[6] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b011, 3'b101};
    logic [1:0]  t_sb[6]  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    logic [17:0] exp_v[4];
    for (int t = 0; t < 6; t++) begin
      exp_v[0] = pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0);
      exp_v[1] = pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0, 0);
      exp_v[2] = pk(0, 0, 0, 0, 2'b00, 2'b10, t_sb[t], 2'b00, t_alu[t], 0, 0, 0);
      exp_v[3] = pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0);
      @(negedge clk);
      op = t_op[t]; funct3 = t_f3[t]; funct7b5 = t_f7[t];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        checks++;
        if (obs() !== exp_v[i]) begin
          errors++;
          $display("[TB] FAIL alu%0d cycle %0d: got %b expected %b", t, i, obs(), exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_beq(input logic zero_in);
    logic [17:0] exp_v[3];
    exp_v[0] = pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0, 0, 0);
    exp_v[1] = pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0, 0, 0);
    exp_v[2] = pk(zero_in, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 1, 0);
    @(negedge clk);
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = zero_in;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("[TB] FAIL beq_z%0b cycle %0d: got %b expected %b", zero_in, i, obs(), exp_v[i]);
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [17:0] exp_v[4];
    exp_v[0] = pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0, 0, 0);
    exp_v[1] = pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000, 0, 0, 0);
    exp_v[2] = pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0, 0);
    exp_v[3] = pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1, 1, 0);
    @(negedge clk);
    op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("[TB] FAIL jal cycle %0d: got %b expected %b", i, obs(), exp_v[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [17:0] exp_v;
    exp_v = pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0);
    @(negedge clk);
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== exp_v) begin
      errors++;
      $display("[TB] FAIL mid_reset: got %b expected %b", obs(), exp_v);
    end
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  task automatic test_trap(input logic [6:0] t_op, input logic [2:0] t_f3);
    logic [17:0] exp_v[2];
    logic [17:0] exp_trap, exp_fetch;
    exp_v[0]  = pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0);
    exp_v[1]  = pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0, 0, 0);
    exp_trap  = pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 1);
    exp_fetch = pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0);
    @(negedge clk);
    op = t_op; funct3 = t_f3; funct7b5 = 1'b0; Zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (obs() !== exp_v[i]) begin
        errors++;
        $display("[TB] FAIL trap_entry op %b cycle %0d: got %b expected %b", t_op, i, obs(), exp_v[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checks++;
      if (obs() !== exp_trap) begin
        errors++;
        $display("[TB] FAIL trap_hold op %b cycle %0d: got %b expected %b", t_op, i, obs(), exp_trap);
      end
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== exp_fetch) begin
      errors++;
      $display("[TB] FAIL trap_reset op %b: got %b expected %b", t_op, obs(), exp_fetch);
    end
    Zero = 1'b0;
    op = 7'b0000011;
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_mid_reset();
    test_lw();
    test_trap(7'b0000000, 3'b000);
    test_trap(7'b0110011, 3'b001);
    test_sw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
